data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed data memory for the load/store stage, successor to the single-word data memory. Supports byte, halfword and word accesses with sign or zero extension. Uses a valid/ready request channel, a fixed-latency response channel, and alignment and range error reporting. Sits between the execute/memory stage and on-chip SRAM storage.

Parameters:
DATA_WIDTH, 32, word width in bits; fixed at 32 for this generation, and any other value is an elaboration error.
DEPTH_WORDS, 1024, number of words; must be a power of two ≥ 2.
ADDR_WIDTH, 32, width of the byte address.
READ_LATENCY, 1, cycles from request accept to response; valid range 1..4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
resp_valid  output  1  response present; one-cycle pulse per accepted request
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_error  output  1  request was misaligned, out of range, or used reserved size

Behaviour:
- Accept condition:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - There is no backpressure on the response channel.
- Word index and byte lane:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Byte lane = req_addr[1:0].
- Error conditions; any one sets the error:
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - req_size = 11.
  - Any address bit above log2(DEPTH_WORDS)+1 is nonzero.
- Erroring stores write nothing. Erroring loads return rdata = 0.
- Stores:
  - The write commits at the accept edge, touching only the addressed lane(s).
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Unaddressed lanes are unchanged.
- Loads:
  - The array is sampled at the accept edge.
  - Lanes are extracted using the same mapping as stores.
  - The result is extended per req_unsigned; word loads ignore req_unsigned.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data.
- Response timing:
  - resp_valid, resp_rdata and resp_error appear exactly READ_LATENCY cycles after the accept edge.
  - They pass through a shift pipeline of READ_LATENCY stages.
  - Back-to-back requests are accepted every cycle, giving full throughput.
- FSM states: INIT, READY.
  - Without the optional feature, INIT lasts 1 cycle after reset deasserts, then the FSM moves to READY.
  - req_ready = 1 only in READY.
- Reset:
  - All pipeline stages are cleared, so resp_valid = 0, resp_rdata = 0 and resp_error = 0 the cycle after reset.
  - FSM goes to INIT and req_ready = 0.
  - In-flight responses are discarded.
  - Array contents are not reset.
- Outputs while reset is asserted: req_ready = 0 and resp_valid = 0.
- A request presented while req_ready = 0 is ignored and must be held by the requester.

Optional Feature:
DMEM_ZERO_INIT_EN.
- Defined:
  - INIT sweeps a counter from 0 to DEPTH_WORDS-1, writing 0 to one word per cycle.
  - req_ready stays 0 for DEPTH_WORDS cycles, then the FSM moves to READY.
  - A reset during the sweep restarts the counter at 0.
- Undefined: there is no sweep, INIT is a single cycle, and contents after power-up are X.

Decomposition:
- Package dmem_pkg holds:
  - Typedef mem_size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD).
  - Typedef dmem_state_e (INIT, READY).
  - Function for lane extraction and extension.
  - Constant for the maximum READ_LATENCY (4).
- One sub-module, dmem_resp_pipe: parametrised shift pipeline of {valid, error, rdata} with synchronous clear.

Test Plan:
- Reset-to-ready: reset for 2 cycles, then release → req_ready rises 1 cycle later, or DEPTH_WORDS cycles later with DMEM_ZERO_INIT_EN.
  - With the feature, a subsequent load from addr 0x10 returns 0x00000000.
- Word round-trip:
  - Store word 0xDEADBEEF at 0x40, then load word from 0x40.
  - resp_rdata = 0xDEADBEEF, READ_LATENCY cycles after the load accept.
  - Repeat for READ_LATENCY = 1 and 3.
- Byte store with sign extension:
  - Word 0x11223344 at 0x80, then store byte 0xF0 to 0x82.
  - Word load from 0x80 → 0x11F03344.
  - Signed byte load from 0x82 → 0xFFFFFFF0; unsigned → 0x000000F0.
- Halfword store with extension:
  - Store half 0x8001 at 0x86.
  - Signed half load from 0x86 → 0xFFFF8001; unsigned → 0x00008001.
- Error cases (each gives resp_error = 1 and rdata = 0):
  - Word load from 0x41.
  - Store to 0x1002 with DEPTH_WORDS = 1024; memory is unchanged afterwards.
  - req_size = 11.
- Throughput and reset:
  - 8 back-to-back loads → 8 consecutive resp_valid pulses in order.
  - Assert reset with 2 loads in flight → no resp_valid after reset, and req_ready = 0 during reset.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// dmem_pkg: shared types, limits and load lane extraction for data_memory_ctrl.
package dmem_pkg;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD} mem_size_e;
    typedef enum logic {INIT, READY} dmem_state_e;

    localparam int MAX_READ_LATENCY = 4;

    // Lane shift aligns the addressed byte/half to bit 0; word loads ignore uns.
    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane,
                                                 input mem_size_e sz, input logic uns);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        return sz == SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
               sz == SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : w;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// dmem_if: request/response bus between the load/store stage and data_memory_ctrl.
interface dmem_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    modport master(output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                   input req_ready, resp_valid, resp_rdata, resp_error);
    modport slave(input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_error);
endinterface

// File: rtl/data_memory_ctrl_resp_pipe.sv
// dmem_resp_pipe: fixed-latency shift pipeline for response payloads with sync clear.
module dmem_resp_pipe #(
    parameter int W      = 34,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed data memory with sized/extended loads and error reporting.
// Optional DMEM_ZERO_INIT_EN: INIT sweeps the array to zero before accepting requests.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    if (DATA_WIDTH != 32 || DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
        READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_param
        $error("data_memory_ctrl: illegal parameter set");
    end

    logic [3:0][7:0] r_mem [DEPTH_WORDS];
    dmem_state_e     r_state;
`ifdef DMEM_ZERO_INIT_EN
    logic [IW-1:0]   r_init_cnt;
`endif

    mem_size_e       w_size;
    logic [IW-1:0]   w_idx;
    logic [1:0]      w_lane;
    logic            w_acc, w_err, w_we;
    logic [3:0]      w_be;
    logic [31:0]     w_wd, w_rdata;
    logic [33:0]     w_q;

    assign w_size  = mem_size_e'(bus.req_size);
    assign w_idx   = bus.req_addr[IW+1:2];
    assign w_lane  = bus.req_addr[1:0];
    assign w_acc   = bus.req_valid & bus.req_ready;
    // Any set bit above the word index would otherwise alias onto a valid word.
    assign w_err   = (w_size == SIZE_H && w_lane[0]) || (w_size == SIZE_W && w_lane != 2'b00) ||
                     w_size == SIZE_RSVD || (bus.req_addr >> (IW + 2)) != '0;
    assign w_we    = w_acc & bus.req_write & ~w_err;
    assign w_be    = w_size == SIZE_B ? 4'b0001 << w_lane :
                     w_size == SIZE_H ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd    = w_size == SIZE_B ? {4{bus.req_wdata[7:0]}} :
                     w_size == SIZE_H ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    assign w_rdata = (bus.req_write || w_err) ? '0 :
                     lane_extract(r_mem[w_idx], w_lane, w_size, bus.req_unsigned);

    always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
        if (!reset && r_state == INIT) r_mem[r_init_cnt] <= '0;
`endif
        if (w_we)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][i] <= w_wd[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
        if (reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == IW'(DEPTH_WORDS - 1)) r_state <= READY;
        end
`else
        r_state <= reset ? INIT : READY;
`endif
    end

    dmem_resp_pipe #(.W(34), .STAGES(READ_LATENCY)) u_pipe (
        .clk   (clk),
        .reset (reset),
        .i_d   ({w_acc, w_acc & w_err, w_rdata}),
        .o_q   (w_q)
    );

    assign bus.req_ready  = r_state == READY && !reset;
    assign bus.resp_valid = w_q[33] & ~reset;
    assign bus.resp_error = w_q[32];
    assign bus.resp_rdata = w_q[31:0];
endmodule
